// File: rtl/shm_pipe.sv
// shm_pipe: pipelined funnel/rotate/shift/select matrix with valid/ready flow control.
// Stage 1 applies the byte-multiple (coarse) shift; the last stage applies the fine shift and parity.
module shm_pipe #(
  parameter int unsigned W      = 36,
  parameter int unsigned CW     = 10,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [CW-1:0]    in_count,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_par,
  output logic             out_inh,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      inh_cnt
);

  localparam int unsigned W2 = 2 * W;

  localparam logic [2:0] M_FUNNEL = 3'd0;
  localparam logic [2:0] M_PASS_A = 3'd1;
  localparam logic [2:0] M_PASS_B = 3'd2;
  localparam logic [2:0] M_SWAP   = 3'd3;
  localparam logic [2:0] M_ROTL   = 3'd4;
  localparam logic [2:0] M_ASHR   = 3'd5;
  localparam logic [2:0] M_LSHR   = 3'd6;

  // Fine shift: left ops take the upper word, right ops take the lower word.
  function automatic logic [W-1:0] fine_sh(input logic [W2-1:0] t, input logic [2:0] f,
                                           input logic right);
    logic [W2-1:0] l;
    logic [W2-1:0] r;
    l = t << f;
    r = t >> f;
    return right ? r[W-1:0] : l[W2-1:W];
  endfunction

  logic [W2-1:0] dec_t;
  logic [2:0]    dec_fine;
  logic          dec_right;
  logic          dec_inh;
  logic          in_range;
  logic          sign;
  logic [CW-1:0] n_coarse;
  logic [CW-1:0] rot_n;
  logic          accept;

  assign in_range = in_count < CW'(W);
  assign rot_n    = in_count % CW'(W);
  assign sign     = in_a[W-1];
  assign n_coarse = {in_count[CW-1:3], 3'b000};
  assign accept   = in_valid && in_ready;

  // Decode every mode into a 2W-bit window plus fine amount and direction.
  always_comb begin
    dec_t     = '0;
    dec_fine  = 3'd0;
    dec_right = 1'b0;
    dec_inh   = 1'b0;
    case (in_mode)
      M_FUNNEL: begin
        if (in_range) begin
          dec_t    = {in_a, in_b} << n_coarse;
          dec_fine = in_count[2:0];
        end else begin
          dec_t   = {in_b, in_b};
          dec_inh = 1'b1;
        end
      end
      M_PASS_A: dec_t = {in_a, in_b};
      M_PASS_B: dec_t = {in_b, in_b};
      M_SWAP:   dec_t = {in_a[W/2-1:0], in_a[W-1:W/2], in_b};
      M_ROTL: begin
        dec_t    = {in_a, in_a} << {rot_n[CW-1:3], 3'b000};
        dec_fine = rot_n[2:0];
      end
      M_ASHR: begin
        dec_right = 1'b1;
        if (in_range) begin
          dec_t    = {{W{sign}}, in_a} >> n_coarse;
          dec_fine = in_count[2:0];
        end else begin
          dec_t   = {W2{sign}};
          dec_inh = 1'b1;
        end
      end
      M_LSHR: begin
        dec_right = 1'b1;
        if (in_range) begin
          dec_t    = {{W{1'b0}}, in_a} >> n_coarse;
          dec_fine = in_count[2:0];
        end else begin
          dec_inh = 1'b1;
        end
      end
      default: dec_inh = 1'b1;
    endcase
  end

  // Saturating count of accepted out-of-range operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cnt <= 16'd0;
    end else if (accept && dec_inh && inh_cnt != 16'hFFFF) begin
      inh_cnt <= inh_cnt + 16'd1;
    end
  end

  if (STAGES == 1) begin : g_one
    logic          ld;
    logic [W-1:0]  res;

    assign ld       = !out_valid || out_ready;
    assign in_ready = ld;
    assign res      = fine_sh(dec_t, dec_fine, dec_right);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_par   <= 1'b1;
        out_inh   <= 1'b0;
        out_tag   <= '0;
      end else if (ld) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= res;
          out_par  <= ~^res;
          out_inh  <= dec_inh;
          out_tag  <= in_tag;
        end
      end
    end
  end else begin : g_two
    logic             s1_valid;
    logic [W2-1:0]    s1_t;
    logic [2:0]       s1_fine;
    logic             s1_right;
    logic             s1_inh;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_ld;
    logic             s1_adv;
    logic [W-1:0]     res;

    assign s2_ld    = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_ld;
    assign in_ready = !s1_valid || s1_adv;
    assign res      = fine_sh(s1_t, s1_fine, s1_right);

    // Stage 1: coarse-shifted window, fine amount, direction, tag and inh.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_t     <= '0;
        s1_fine  <= 3'd0;
        s1_right <= 1'b0;
        s1_inh   <= 1'b0;
        s1_tag   <= '0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_t     <= dec_t;
          s1_fine  <= dec_fine;
          s1_right <= dec_right;
          s1_inh   <= dec_inh;
          s1_tag   <= in_tag;
        end
      end
    end

    // Stage 2: fine shift result and parity, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_par   <= 1'b1;
        out_inh   <= 1'b0;
        out_tag   <= '0;
      end else if (s2_ld) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_par  <= ~^res;
          out_inh  <= s1_inh;
          out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule
